// File: rtl/vlsu_cam.sv
// Multi-port CAM tracking in-flight vector load/store entries.
// Each search port returns the first hit scanning circularly from the queue head.

module vlsu_cam_port #(
  parameter int WIDTH = 50,
  parameter int DEPTH = 32,
  parameter int AW    = 5
) (
  input  logic [DEPTH-1:0][WIDTH-1:0] tag_i,
  input  logic [DEPTH-1:0]            valid_i,
  input  logic [DEPTH-1:0]            enable_i,
  input  logic                        read_i,
  input  logic [WIDTH-1:0]            key_i,
  input  logic [AW-1:0]               head_i,
  output logic                        match_o,
  output logic [AW-1:0]               addr_o
);
  logic [DEPTH-1:0] hit;
  logic [DEPTH-1:0] hit_rot;

  always_comb begin
    hit = '0;
    for (int e = 0; e < DEPTH; e++)
      hit[e] = read_i & valid_i[e] & enable_i[e] & (tag_i[e] == key_i);
  end

  // Rotate so bit 0 is the head entry; AW-bit add wraps modulo DEPTH.
  always_comb begin
    hit_rot = '0;
    for (int i = 0; i < DEPTH; i++)
      hit_rot[i] = hit[AW'(i) + head_i];
  end

  always_comb begin
    match_o = |hit_rot;
    addr_o  = '0;
    for (int i = DEPTH - 1; i >= 0; i--)
      if (hit_rot[i]) addr_o = AW'(i) + head_i;
  end
endmodule

module vlsu_cam #(
  parameter int WIDTH = 50,
  parameter int DEPTH = 32,
  parameter int WRITE = 1,
  parameter int READ  = 3,
  localparam int ADDRESS = $clog2(DEPTH)
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [ADDRESS-1:0]                head_i,
  input  logic [READ-1:0][DEPTH-1:0]        enable_i,
  input  logic [WRITE-1:0]                  write_i,
  input  logic [WRITE-1:0][ADDRESS-1:0]     write_addr_i,
  input  logic [WRITE-1:0][WIDTH-1:0]       write_data_i,
  input  logic [READ-1:0]                   read_i,
  input  logic [READ-1:0][WIDTH-1:0]        read_data_i,
  output logic [READ-1:0]                   match_o,
  output logic [READ-1:0][ADDRESS-1:0]      match_data_o
);
  logic [DEPTH-1:0][WIDTH-1:0]  tag_q, tag_d;
  logic [DEPTH-1:0]             valid_q, valid_d;
  logic [READ-1:0]              match_q, match_d;
  logic [READ-1:0][ADDRESS-1:0] match_data_q, match_data_d;

  // Ascending port order lets the highest-index writer win an address collision.
  always_comb begin
    tag_d   = tag_q;
    valid_d = valid_q;
    for (int w = 0; w < WRITE; w++) begin
      if (write_i[w]) begin
        tag_d[write_addr_i[w]]   = write_data_i[w];
        valid_d[write_addr_i[w]] = 1'b1;
      end
    end
  end

  // Search ports see pre-edge storage, so same-cycle writes are not bypassed.
  for (genvar r = 0; r < READ; r++) begin : g_port
    vlsu_cam_port #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH),
      .AW    (ADDRESS)
    ) u_port (
      .tag_i    (tag_q),
      .valid_i  (valid_q),
      .enable_i (enable_i[r]),
      .read_i   (read_i[r]),
      .key_i    (read_data_i[r]),
      .head_i   (head_i),
      .match_o  (match_d[r]),
      .addr_o   (match_data_d[r])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tag_q        <= '0;
      valid_q      <= '0;
      match_q      <= '0;
      match_data_q <= '0;
    end else begin
      tag_q        <= tag_d;
      valid_q      <= valid_d;
      match_q      <= match_d;
      match_data_q <= match_data_d;
    end
  end

  assign match_o      = match_q;
  assign match_data_o = match_data_q;
endmodule

// File: tb/tb_vlsu_cam.sv
// Scoreboard bench for vlsu_cam: each driven cycle pushes its expected per-port
// result, popped and compared one cycle later.

module tb_vlsu_cam;
  localparam int WIDTH = 50;
  localparam int DEPTH = 32;
  localparam int WRITE = 1;
  localparam int READ  = 3;
  localparam int AW    = 5;

  logic                        clk = 1'b0;
  logic                        rst;
  logic [AW-1:0]               head_i;
  logic [READ-1:0][DEPTH-1:0]  enable_i;
  logic [WRITE-1:0]            write_i;
  logic [WRITE-1:0][AW-1:0]    write_addr_i;
  logic [WRITE-1:0][WIDTH-1:0] write_data_i;
  logic [READ-1:0]             read_i;
  logic [READ-1:0][WIDTH-1:0]  read_data_i;
  logic [READ-1:0]             match_o;
  logic [READ-1:0][AW-1:0]     match_data_o;

  typedef struct {
    string               tag;
    logic [READ-1:0]     m;
    logic [READ-1:0][AW-1:0] a;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  vlsu_cam #(.WIDTH(WIDTH), .DEPTH(DEPTH), .WRITE(WRITE), .READ(READ)) dut (
    .clk          (clk),
    .rst          (rst),
    .head_i       (head_i),
    .enable_i     (enable_i),
    .write_i      (write_i),
    .write_addr_i (write_addr_i),
    .write_data_i (write_data_i),
    .read_i       (read_i),
    .read_data_i  (read_data_i),
    .match_o      (match_o),
    .match_data_o (match_data_o)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Push expectation, clock once, pop and compare; strobes return to idle.
  task automatic tick(input string tag, input logic [READ-1:0] em,
                      input logic [READ-1:0][AW-1:0] ea);
    exp_t e;
    e.tag = tag; e.m = em; e.a = ea;
    sb.push_back(e);
    @(posedge clk); #1;
    e = sb.pop_front();
    for (int r = 0; r < READ; r++) begin
      chk($sformatf("%s.m%0d", e.tag, r), 32'(match_o[r]), 32'(e.m[r]));
      chk($sformatf("%s.a%0d", e.tag, r), 32'(match_data_o[r]), 32'(e.a[r]));
    end
    rst = 1'b0; write_i = '0; read_i = '0;
  endtask

  task automatic idle(input string tag);
    tick(tag, '0, '0);
  endtask

  task automatic wr(input int addr, input logic [WIDTH-1:0] data);
    write_i[0] = 1'b1; write_addr_i[0] = AW'(addr); write_data_i[0] = data;
  endtask

  // Same key on all ports, all expected to agree.
  task automatic srch_all(input string tag, input logic [WIDTH-1:0] key, input int head,
                          input logic hit, input int addr);
    logic [READ-1:0][AW-1:0] ea;
    head_i = AW'(head);
    for (int r = 0; r < READ; r++) begin
      read_i[r] = 1'b1; read_data_i[r] = key;
      ea[r] = hit ? AW'(addr) : '0;
    end
    tick(tag, hit ? '1 : '0, ea);
  endtask

  task automatic srch1(input string tag, input int p, input logic [WIDTH-1:0] key,
                       input logic hit, input int addr);
    logic [READ-1:0] em;
    logic [READ-1:0][AW-1:0] ea;
    em = '0; ea = '0;
    read_i[p] = 1'b1; read_data_i[p] = key;
    em[p] = hit; ea[p] = hit ? AW'(addr) : '0;
    tick(tag, em, ea);
  endtask

  initial begin
    logic [READ-1:0][AW-1:0] ea;
    rst = 1'b1; head_i = '0; enable_i = '1; write_i = '0; write_addr_i = '0;
    write_data_i = '0; read_i = '0; read_data_i = '0;

    // Reset wins over a same-cycle write and search.
    rst = 1'b1; wr(5, 50'h77); read_i = '1;
    idle("rst");
    srch_all("rst_key0", 50'h0, 0, 1'b0, 0);
    srch_all("rst_wr_dropped", 50'h77, 0, 1'b0, 0);

    for (int j = 0; j < 8; j++) begin
      wr(j, 50'(j + 1));
      idle("wr");
      idle("wr_gap");
    end

    for (int p = 0; p < READ; p++)
      for (int k = 8; k >= 1; k--)
        srch1($sformatf("basic_p%0d_k%0d", p, k), p, 50'(k), 1'b1, k - 1);

    srch_all("miss9", 50'd9, 0, 1'b0, 0);
    srch_all("miss0", 50'd0, 0, 1'b0, 0);

    wr(4, 50'd5);  idle("wr4");
    wr(20, 50'd5); idle("wr20");
    srch_all("circ_h0", 50'd5, 0, 1'b1, 4);
    srch_all("circ_h10", 50'd5, 10, 1'b1, 20);
    srch_all("circ_h21", 50'd5, 21, 1'b1, 4);
    srch_all("circ_h4", 50'd5, 4, 1'b1, 4);
    srch_all("circ_h5", 50'd5, 5, 1'b1, 20);
    srch_all("circ_h31", 50'd5, 31, 1'b1, 4);

    // Per-port enable masks: port1 loses 20, port0 loses both, port2 untouched.
    enable_i[1][20] = 1'b0;
    enable_i[0][4] = 1'b0; enable_i[0][20] = 1'b0;
    head_i = AW'(10); read_i = '1;
    read_data_i[0] = 50'd5; read_data_i[1] = 50'd5; read_data_i[2] = 50'd5;
    ea[0] = '0; ea[1] = AW'(4); ea[2] = AW'(20);
    tick("enable", 3'b110, ea);
    enable_i = '1;

    // No bypass: same-cycle write is invisible to the search.
    head_i = '0;
    wr(3, 50'h2A); read_i[0] = 1'b1; read_data_i[0] = 50'h2A;
    tick("wr_same_cyc", '0, '0);
    srch1("wr_next_cyc", 0, 50'h2A, 1'b1, 3);
    srch1("overwrite_old", 1, 50'd4, 1'b0, 0);
    srch1("wide_key", 2, 50'h2_0000_0000_002A, 1'b0, 0);

    rst = 1'b1; read_i = '1; read_data_i[0] = 50'd1; read_data_i[1] = 50'd5;
    read_data_i[2] = 50'h2A;
    idle("rst_mid");
    srch1("post_rst_k1", 0, 50'd1, 1'b0, 0);
    srch1("post_rst_k5", 1, 50'd5, 1'b0, 0);
    srch1("post_rst_2a", 2, 50'h2A, 1'b0, 0);
    wr(0, 50'd1); idle("rewr0");
    srch1("rewr_k1", 2, 50'd1, 1'b1, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/vlsu_cam.md
Name: vlsu_cam

Overview:
- Multi-port content-addressable memory used by the vector load/store unit to track in-flight entries.
- Each entry holds a WIDTH-bit tag and a valid bit, and is written by address.
- READ independent search ports each compare a key against all valid, enabled entries.
- Each search port returns the address of the first hit, scanning circularly from a head pointer (oldest-first in the queue).

Parameters:
- WIDTH, 50, bits per stored tag / search key
- DEPTH, 32, number of entries (power of two)
- WRITE, 1, number of write ports
- READ, 3, number of search (read) ports
- ADDRESS, $clog2(DEPTH), entry address width (derived, not overridable)

Ports:
- clk  input  1  single clock, all state on rising edge
- rst  input  1  synchronous reset, active high
- head_i  input  ADDRESS  circular priority start index (queue head)
- enable_i  input  READ x DEPTH  per-port, per-entry compare enable mask
- write_i  input  WRITE  per-port write strobe
- write_addr_i  input  WRITE x ADDRESS  entry written by each write port
- write_data_i  input  WRITE x WIDTH  tag written by each write port
- read_i  input  READ  per-port search strobe
- read_data_i  input  READ x WIDTH  search key per port
- match_o  output  READ  per-port hit flag
- match_data_o  output  READ x ADDRESS  per-port address of selected hit

Behaviour:
- Reset (rst=1 at posedge):
  - All valid bits, match_o and match_data_o go to 0.
  - Tag storage is also cleared to 0.
  - Reset has priority over any same-cycle write or search; an in-progress search produces no result.
- Write:
  - At posedge with write_i[w]=1, entry[write_addr_i[w]] takes write_data_i[w] and its valid bit is set.
  - Entries are never invalidated except by reset.
  - Overwriting a valid entry replaces its tag.
  - If two write ports target the same address in the same cycle, the higher port index wins.
- Search, evaluated per port r:
  - hit[e] = read_i[r] & valid[e] & enable_i[r][e] & (tag[e] == read_data_i[r]).
  - Compare uses storage state before the posedge. A write in the same cycle is not visible until the following cycle; there is no bypass.
- Priority select:
  - Scan e = head_i, head_i+1, …, DEPTH-1, 0, …, head_i-1 (modulo DEPTH wrap-around).
  - The first set hit[e] is selected.
- Output timing:
  - Outputs are registered with 1-cycle latency: search inputs sampled at posedge N appear on match_o/match_data_o after posedge N.
  - Outputs hold until the next posedge.
- No-hit / idle:
  - Any hit → match_o[r]=1 and match_data_o[r] = selected address.
  - No hit, or read_i[r]=0 → match_o[r]=0 and match_data_o[r]=0.
- Port independence: all READ ports search simultaneously and independently, and may return the same address.
- head_i is sampled in the same cycle as the search inputs.
- Search and write ports are fully independent; any combination may be active in the same cycle.
- enable_i bit at 0 excludes that entry for that port only.
- No handshake or backpressure; a new search may be issued every cycle.

Test Plan:
- Basic hit: reset, then write addr j with data j+1 for j=0..7 (one write per 2 cycles), head_i=0, all enables 1.
  - Search port 0 with keys 8,7,…,1 on successive cycles → match_o[0]=1 and match_data_o[0]=7,6,…,0, each one cycle after its key.
  - Repeat on ports 1 and 2 → same results.
- Miss: after the basic-hit writes, search key 9 or key 0 → match_o=0, match_data_o=0.
  - After reset, search key 0 (all entries invalid) → no match, even though the reset tags are 0.
- Circular priority: write data 5 to addr 4 and addr 20.
  - Search key 5 with head_i=0 → 4.
  - head_i=10 → 20.
  - head_i=21 → 4 (wrap).
  - head_i=4 → 4.
- Enable mask: with the data-5 entries above, clear enable_i[1][20], head_i=10, search port 1 key 5 → 4.
  - Port 2 with all enables set, same key and head → 20.
  - Clear both bits 4 and 20 on a port → no match.
- Write/search same cycle: write addr 3 data 0x2A while searching key 0x2A → no match that result.
  - Searching again the next cycle → match, address 3.
- Reset mid-operation: with entries valid and read_i active, assert rst for 1 cycle → outputs 0 the next cycle.
  - Subsequent searches of previously written keys → no match until rewritten.
